fft_frame_ctrl: RTL and testbench

Frame sequencer for the 512-point FFT core.
- Collects one frame of 2^N real samples from the audio sample stream and writes them into the core through its load port.
- Holds the core's start level until the core reports done, then streams the first 2^(N-1) bins out through a valid/ready interface with a 2-entry skid buffer.
- Sits between the ADC/sample front end and the downstream magnitude/peak logic; owns all core control pins.

---
 rtl/fft_frame_ctrl_pkg.sv | 22 ++
 rtl/fft_frame_ctrl_if.sv | 29 ++
 rtl/fft_frame_ctrl_skid.sv | 46 ++++
 rtl/fft_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and sizes for the FFT frame sequencer.
// States, complex bin type and default frame geometry.
package fft_pkg;

    localparam int FFT_BW    = 16;
    localparam int FFT_N     = 9;
    localparam int FRAME_LEN = 2 ** FFT_N;
    localparam int HALF_LEN  = 2 ** (FFT_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        READ
    } state_t;

    typedef struct packed {
        logic signed [FFT_BW-1:0] re;
        logic signed [FFT_BW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Bin output stream of the FFT frame sequencer.
// Valid/ready handshake carrying {real, imag} and the bin number.
interface fft_frame_ctrl_if
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = FFT_BW,
    parameter int N         = FFT_N
);

    logic                   bin_valid;
    logic                   bin_ready;
    logic [2*BIT_WIDTH-1:0] bin_data;
    logic [N-2:0]           bin_idx;

    modport master (
        output bin_valid,
        output bin_data,
        output bin_idx,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_data,
        input  bin_idx,
        output bin_ready
    );

endinterface

// File: rtl/fft_frame_ctrl_skid.sv
// Two-entry in-order buffer between core readout and the bin stream.
// The writer must never push while full; occ lets it budget reads.
module fft_skid2
    import fft_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;

    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: load 2^N samples, run the core, stream 2^(N-1) bins.
// Define FFT_FRAME_CTRL_OVERRUN_EN to count samples dropped outside LOAD.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH      = 16,
    parameter int N              = 9,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int CNT_W          = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   sample_valid,
    input  logic [BIT_WIDTH-1:0]   sample_in,
    output logic                   fft_load,
    output logic                   fft_start,
    output logic [N-1:0]           add_rd,
    output logic [BIT_WIDTH-1:0]   din,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] dout,
    output logic                   core_rst,
    fft_frame_ctrl_if.master       bin_if,
    output logic                   frame_done,
    output logic                   fft_err
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
    ,
    output logic [15:0]            overrun_cnt,
    output logic                   overrun
`endif
);

    localparam int HLEN = 2 ** (N - 1);
    localparam int SW   = N - 1 + 2 * BIT_WIDTH;
    localparam logic [N-1:0] LOAD_LAST = '1;
    localparam logic [N-2:0] BIN_LAST  = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t         state;
    state_t         state_n;
    logic [N-1:0]   load_cnt;
    logic [N-1:0]   rd_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic           inflight_q;
    logic [N-2:0]   inflight_idx;
    logic           issue;
    logic           to_hit;
    logic           last_pop;
    logic [1:0]     occ;
    logic           sk_valid;
    logic [SW-1:0]  sk_data;

    fft_skid2 #(.W(SW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   ({inflight_idx, dout}),
        .out_valid (sk_valid),
        .out_ready (bin_if.bin_ready),
        .out_data  (sk_data),
        .occ       (occ)
    );

    assign bin_if.bin_valid = sk_valid;
    assign bin_if.bin_data  = sk_data[2*BIT_WIDTH-1:0];
    assign bin_if.bin_idx   = sk_data[SW-1:2*BIT_WIDTH];

    assign last_pop = (state == READ) && sk_valid && bin_if.bin_ready
                   && (bin_if.bin_idx == BIN_LAST);

    always_comb begin
        state_n   = state;
        fft_load  = 1'b0;
        fft_start = 1'b0;
        add_rd    = '0;
        din       = '0;
        core_rst  = 1'b0;
        issue     = 1'b0;
        to_hit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) state_n = LOAD;
            end
            LOAD: begin
                fft_load = 1'b1;
                if (sample_valid) begin
                    din    = sample_in;
                    add_rd = load_cnt;
                    if (load_cnt == LOAD_LAST) state_n = RUN;
                end
            end
            RUN: begin
                if (fft_done) begin
                    fft_start = 1'b1;
                    state_n   = READ;
                end else if (to_cnt == TO_LAST) begin
                    to_hit   = 1'b1;
                    core_rst = 1'b1;
                    state_n  = IDLE;
                end else begin
                    fft_start = 1'b1;
                end
            end
            READ: begin
                // Credit counts the read in flight so the skid never overfills.
                fft_start = 1'b1;
                issue = (rd_cnt < N'(HLEN))
                     && ((occ + {1'b0, inflight_q}) < 2'd2);
                if (issue) add_rd = rd_cnt;
                if (last_pop) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            load_cnt     <= '0;
            rd_cnt       <= '0;
            to_cnt       <= '0;
            inflight_q   <= 1'b0;
            inflight_idx <= '0;
            frame_done   <= 1'b0;
            fft_err      <= 1'b0;
        end else begin
            state      <= state_n;
            frame_done <= last_pop;
            inflight_q <= issue;
            if (issue) inflight_idx <= rd_cnt[N-2:0];
            if (to_hit) fft_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    load_cnt <= '0;
                    rd_cnt   <= '0;
                    to_cnt   <= '0;
                end
                LOAD: begin
                    if (sample_valid && load_cnt != LOAD_LAST)
                        load_cnt <= load_cnt + N'(1);
                end
                RUN: begin
                    if (to_cnt != TO_LAST) to_cnt <= to_cnt + CNT_W'(1);
                end
                READ: begin
                    if (issue) rd_cnt <= rd_cnt + N'(1);
                end
            endcase
        end
    end

`ifdef FFT_FRAME_CTRL_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt <= '0;
            overrun     <= 1'b0;
        end else if (sample_valid && state != LOAD) begin
            overrun <= 1'b1;
            if (overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural FFT core model.
// Build with FFT_FRAME_CTRL_OVERRUN_EN to exercise the overrun counter.
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        fft_load;
    logic        fft_start;
    logic [8:0]  add_rd;
    logic [15:0] din;
    logic        fft_done = 1'b0;
    logic [31:0] dout = '0;
    logic        core_rst;
    logic        frame_done;
    logic        fft_err;
    logic        bin_ready;
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
    logic [15:0] overrun_cnt;
    logic        overrun;
`endif

    fft_frame_ctrl_if #(.BIT_WIDTH(16), .N(9)) bif ();
    assign bif.bin_ready = bin_ready;

    fft_frame_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .fft_load     (fft_load),
        .fft_start    (fft_start),
        .add_rd       (add_rd),
        .din          (din),
        .fft_done     (fft_done),
        .dout         (dout),
        .core_rst     (core_rst),
        .bin_if       (bif),
        .frame_done   (frame_done),
        .fft_err      (fft_err)
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
        ,
        .overrun_cnt  (overrun_cnt),
        .overrun      (overrun)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit pat      = 1'b0;
    bit withhold = 1'b0;
    int rmode    = 0;
    bit held     = 1'b0;
    int core_cnt = 0;

    int wr_total = 0, wr_bad = 0, wr_idx = 0;
    int load_hi = 0, start_hi = 0, rst_hi = 0, fd_hi = 0;
    int bin_total = 0, bin_bad = 0, bin_exp = 0;

    function automatic logic [31:0] core_val(input logic [8:0] a);
        cplx_t c;
        c.re = 16'(a * 5 + 3);
        c.im = 16'hA000 ^ {7'd0, a};
        return c;
    endfunction

    function automatic logic [15:0] samp_val(input int i);
        return pat ? 16'(i * 7 + 1) : 16'h0100;
    endfunction

    // Core model: registered readout, done after 40 start cycles
    always @(posedge clk) begin
        dout <= core_val(add_rd);
        if (!fft_start) begin
            core_cnt <= 0;
            fft_done <= 1'b0;
        end else begin
            core_cnt <= core_cnt + 1;
            fft_done <= !withhold && core_cnt >= 39;
        end
    end

    always @(negedge clk) begin
        if (fft_load) load_hi <= load_hi + 1;
        if (fft_start) start_hi <= start_hi + 1;
        if (core_rst) rst_hi <= rst_hi + 1;
        if (frame_done) fd_hi <= fd_hi + 1;
        if (fft_load && sample_valid) begin
            if (add_rd !== 9'(wr_idx) || din !== samp_val(wr_idx))
                wr_bad <= wr_bad + 1;
            wr_idx   <= wr_idx + 1;
            wr_total <= wr_total + 1;
        end else if (!fft_load) begin
            wr_idx <= 0;
        end
        if (reset || frame_done) begin
            bin_exp <= 0;
        end else if (bif.bin_valid && bin_ready) begin
            if (bif.bin_idx !== 8'(bin_exp)
                || bif.bin_data !== core_val(9'(bin_exp)))
                bin_bad <= bin_bad + 1;
            bin_exp   <= bin_exp + 1;
            bin_total <= bin_total + 1;
        end
    end

    initial begin
        bin_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) begin
                bin_ready = 1'b1;
            end else if (bin_exp == 100 && !held) begin
                held = 1'b1;
                bin_ready = 1'b0;
                repeat (19) @(posedge clk);
            end else begin
                bin_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int gap, input int n);
        int k = 0;
        run = 1'b1;
        while (!fft_load && k < 10) begin
            step();
            k++;
        end
        run = 1'b0;
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_in = samp_val(i);
            step();
            sample_valid = 1'b0;
            sample_in = '0;
            repeat (gap) step();
        end
    endtask

    task automatic wait_frame(input int base_fd, input int budget);
        int k = 0;
        while (fd_hi == base_fd && k < budget) begin
            step();
            k++;
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample_valid = 1'b1;
        sample_in = 16'h1234;
        step();
        step();
        chk_cnt++;
        if ({fft_load, fft_start, core_rst, frame_done, fft_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {fft_load, fft_start, core_rst, frame_done, fft_err});
        else pass_cnt++;
        chk_cnt++;
        if ({add_rd, din} !== 25'd0)
            $display("FAIL reset_bus: add_rd=%0h din=%0h want 0", add_rd, din);
        else pass_cnt++;
        chk_cnt++;
        if ({bif.bin_valid, bif.bin_idx, bif.bin_data} !== 41'd0)
            $display("FAIL reset_bin: valid=%b idx=%0h want 0",
                     bif.bin_valid, bif.bin_idx);
        else pass_cnt++;
        reset = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        step();
    endtask

    task automatic test_frame();
        int b_ld = load_hi, b_wr = wr_total, b_wb = wr_bad;
        int b_fd = fd_hi, b_bt = bin_total, b_bb = bin_bad;
        pat = 1'b0;
        rmode = 0;
        load_frame(0, 512);
        chk_cnt++;
        if ({fft_start, fft_load} !== 2'b10)
            $display("FAIL start_after_load: start,load=%b want 10",
                     {fft_start, fft_load});
        else pass_cnt++;
        chk_cnt++;
        if (load_hi - b_ld !== 512)
            $display("FAIL load_cycles: got %0d want 512", load_hi - b_ld);
        else pass_cnt++;
        wait_frame(b_fd, 3000);
        chk_cnt++;
        if (wr_total - b_wr !== 512 || wr_bad - b_wb !== 0)
            $display("FAIL frame_writes: got %0d bad %0d want 512 bad 0",
                     wr_total - b_wr, wr_bad - b_wb);
        else pass_cnt++;
        chk_cnt++;
        if (bin_total - b_bt !== 256 || bin_bad - b_bb !== 0)
            $display("FAIL frame_bins: got %0d bad %0d want 256 bad 0",
                     bin_total - b_bt, bin_bad - b_bb);
        else pass_cnt++;
        chk_cnt++;
        if (fd_hi - b_fd !== 1)
            $display("FAIL frame_done_pulse: got %0d want 1", fd_hi - b_fd);
        else pass_cnt++;
        chk_cnt++;
        if ({fft_start, fft_load} !== 2'b00)
            $display("FAIL frame_idle: start,load=%b want 00",
                     {fft_start, fft_load});
        else pass_cnt++;
    endtask

    task automatic test_gapped();
        int b_wr = wr_total, b_wb = wr_bad;
        int b_fd = fd_hi, b_bt = bin_total, b_bb = bin_bad;
        pat = 1'b1;
        load_frame(2, 512);
        wait_frame(b_fd, 3000);
        chk_cnt++;
        if (wr_total - b_wr !== 512 || wr_bad - b_wb !== 0)
            $display("FAIL gap_writes: got %0d bad %0d want 512 bad 0",
                     wr_total - b_wr, wr_bad - b_wb);
        else pass_cnt++;
        chk_cnt++;
        if (bin_total - b_bt !== 256 || bin_bad - b_bb !== 0
            || fd_hi - b_fd !== 1)
            $display("FAIL gap_bins: got %0d bad %0d done %0d want 256 0 1",
                     bin_total - b_bt, bin_bad - b_bb, fd_hi - b_fd);
        else pass_cnt++;
    endtask

    task automatic test_ready_random();
        int b_fd = fd_hi, b_bt = bin_total, b_bb = bin_bad;
        pat = 1'b0;
        rmode = 1;
        load_frame(0, 512);
        wait_frame(b_fd, 5000);
        rmode = 0;
        chk_cnt++;
        if (bin_total - b_bt !== 256)
            $display("FAIL rand_count: got %0d want 256", bin_total - b_bt);
        else pass_cnt++;
        chk_cnt++;
        if (bin_bad - b_bb !== 0)
            $display("FAIL rand_order: got %0d bad want 0", bin_bad - b_bb);
        else pass_cnt++;
        chk_cnt++;
        if (fd_hi - b_fd !== 1)
            $display("FAIL rand_done: got %0d want 1", fd_hi - b_fd);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int k = 0;
        int b_sh = start_hi, b_rst = rst_hi;
        int b_fd, b_bt, b_bb;
        withhold = 1'b1;
        load_frame(0, 512);
        while (rst_hi == b_rst && k < 9000) begin
            step();
            k++;
        end
        step();
        chk_cnt++;
        if (start_hi - b_sh !== 8191)
            $display("FAIL to_start_cycles: got %0d want 8191", start_hi - b_sh);
        else pass_cnt++;
        chk_cnt++;
        if (rst_hi - b_rst !== 1)
            $display("FAIL to_core_rst: got %0d want 1", rst_hi - b_rst);
        else pass_cnt++;
        chk_cnt++;
        if ({fft_err, fft_start, fft_load} !== 3'b100)
            $display("FAIL to_state: err,start,load=%b want 100",
                     {fft_err, fft_start, fft_load});
        else pass_cnt++;
        withhold = 1'b0;
        b_fd = fd_hi;
        b_bt = bin_total;
        b_bb = bin_bad;
        load_frame(0, 512);
        wait_frame(b_fd, 3000);
        chk_cnt++;
        if (bin_total - b_bt !== 256 || bin_bad - b_bb !== 0
            || fd_hi - b_fd !== 1)
            $display("FAIL to_recover: got %0d bad %0d done %0d want 256 0 1",
                     bin_total - b_bt, bin_bad - b_bb, fd_hi - b_fd);
        else pass_cnt++;
        chk_cnt++;
        if (fft_err !== 1'b1)
            $display("FAIL to_err_sticky: got %b want 1", fft_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int b_fd = fd_hi;
        int b_wr, b_wb, b_bt, b_bb;
        pat = 1'b1;
        load_frame(0, 300);
        reset = 1'b1;
        sample_valid = 1'b1;
        sample_in = 16'h7fff;
        step();
        chk_cnt++;
        if ({fft_load, fft_start, fft_err, add_rd, din} !== 28'd0)
            $display("FAIL mid_reset_out: load=%b start=%b err=%b add=%0h din=%0h want 0",
                     fft_load, fft_start, fft_err, add_rd, din);
        else pass_cnt++;
        reset = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        step();
        step();
        chk_cnt++;
        if (fd_hi - b_fd !== 0)
            $display("FAIL mid_no_done: got %0d want 0", fd_hi - b_fd);
        else pass_cnt++;
        b_wr = wr_total;
        b_wb = wr_bad;
        b_bt = bin_total;
        b_bb = bin_bad;
        b_fd = fd_hi;
        load_frame(0, 512);
        wait_frame(b_fd, 3000);
        chk_cnt++;
        if (wr_total - b_wr !== 512 || wr_bad - b_wb !== 0)
            $display("FAIL mid_restart: got %0d bad %0d want 512 bad 0",
                     wr_total - b_wr, wr_bad - b_wb);
        else pass_cnt++;
        chk_cnt++;
        if (bin_total - b_bt !== 256 || bin_bad - b_bb !== 0)
            $display("FAIL mid_bins: got %0d bad %0d want 256 bad 0",
                     bin_total - b_bt, bin_bad - b_bb);
        else pass_cnt++;
    endtask

`ifdef FFT_FRAME_CTRL_OVERRUN_EN
    task automatic test_overrun();
        int b_wr, b_wb, b_bt, b_fd;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_cnt++;
        if ({overrun, overrun_cnt} !== 17'd0)
            $display("FAIL ovr_reset: got %b/%0d want 0/0", overrun, overrun_cnt);
        else pass_cnt++;
        b_wr = wr_total;
        b_wb = wr_bad;
        b_bt = bin_total;
        b_fd = fd_hi;
        pat = 1'b0;
        load_frame(0, 512);
        repeat (10) begin
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            step();
        end
        wait_frame(b_fd, 3000);
        chk_cnt++;
        if (overrun_cnt !== 16'd10 || overrun !== 1'b1)
            $display("FAIL ovr_count: got %0d/%b want 10/1", overrun_cnt, overrun);
        else pass_cnt++;
        chk_cnt++;
        if (wr_total - b_wr !== 512 || wr_bad - b_wb !== 0
            || bin_total - b_bt !== 256)
            $display("FAIL ovr_frame: wr %0d bad %0d bins %0d want 512 0 256",
                     wr_total - b_wr, wr_bad - b_wb, bin_total - b_bt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_gapped();
        test_ready_random();
        test_timeout();
        test_reset_mid();
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
        test_overrun();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
